// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master DRAM read-channel arbiter.
package arb_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic [AXI_ID_BITS-1:0]   id;
        logic [AXI_ADDR_BITS-1:0] addr;
        logic [AXI_LEN_BITS-1:0]  len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } ar_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to prio.
module rr_arb2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    always_comb begin
        if (&req) gnt = (prio == M1) ? 2'b10 : 2'b01;
        else      gnt = req;
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Two-master AXI read arbiter: one burst at a time, grant locked until RLAST,
// owner bit tagged into ARID_S and R beats steered back by the latched owner.
module dram_rd_arbiter
    import arb_pkg::*;
#(
    parameter int IDW  = AXI_ID_BITS,
    parameter int IDSW = AXI_IDS_BITS,
    parameter int AW   = AXI_ADDR_BITS,
    parameter int DW   = AXI_DATA_BITS,
    parameter int LW   = AXI_LEN_BITS
) (
    input  logic            ACLK,
    input  logic            ARESET,

    input  logic [IDW-1:0]  ARID_M0,
    input  logic [AW-1:0]   ARADDR_M0,
    input  logic [LW-1:0]   ARLEN_M0,
    input  logic [2:0]      ARSIZE_M0,
    input  logic [1:0]      ARBURST_M0,
    input  logic            ARVALID_M0,
    output logic            ARREADY_M0,
    output logic [IDW-1:0]  RID_M0,
    output logic [DW-1:0]   RDATA_M0,
    output logic [1:0]      RRESP_M0,
    output logic            RLAST_M0,
    output logic            RVALID_M0,
    input  logic            RREADY_M0,

    input  logic [IDW-1:0]  ARID_M1,
    input  logic [AW-1:0]   ARADDR_M1,
    input  logic [LW-1:0]   ARLEN_M1,
    input  logic [2:0]      ARSIZE_M1,
    input  logic [1:0]      ARBURST_M1,
    input  logic            ARVALID_M1,
    output logic            ARREADY_M1,
    output logic [IDW-1:0]  RID_M1,
    output logic [DW-1:0]   RDATA_M1,
    output logic [1:0]      RRESP_M1,
    output logic            RLAST_M1,
    output logic            RVALID_M1,
    input  logic            RREADY_M1,

    output logic [IDSW-1:0] ARID_S,
    output logic [AW-1:0]   ARADDR_S,
    output logic [LW-1:0]   ARLEN_S,
    output logic [2:0]      ARSIZE_S,
    output logic [1:0]      ARBURST_S,
    output logic            ARVALID_S,
    input  logic            ARREADY_S,
    input  logic [IDSW-1:0] RID_S,
    input  logic [DW-1:0]   RDATA_S,
    input  logic [1:0]      RRESP_S,
    input  logic            RLAST_S,
    input  logic            RVALID_S,
    output logic            RREADY_S,

    output logic            PROT_ERR
);

    state_t        state_q, state_d;
    logic          rr_prio_q;
    logic          owner_q;
    logic [LW-1:0] beat_q;
    ar_req_t       req_q;
    ar_req_t       win_req;
    logic          prot_err_q;

    logic [1:0]    gnt;
    logic          owner_rready;
    logic          r_hs;
    logic          rid_bad;
    logic          len_bad;
    logic          unused_rid_hi;

    rr_arb2 u_rr_arb2 (
        .req  ({ARVALID_M1, ARVALID_M0}),
        .prio (rr_prio_q),
        .gnt  (gnt)
    );

    always_comb begin
        win_req = '{id: ARID_M0, addr: ARADDR_M0, len: ARLEN_M0,
                    size: ARSIZE_M0, burst: ARBURST_M0};
        if (gnt[1])
            win_req = '{id: ARID_M1, addr: ARADDR_M1, len: ARLEN_M1,
                        size: ARSIZE_M1, burst: ARBURST_M1};
    end

    assign owner_rready = (owner_q == M1) ? RREADY_M1 : RREADY_M0;
    assign r_hs         = (state_q == DATA) && RVALID_S && owner_rready;
    assign rid_bad      = (RID_S[IDW] != owner_q);
    // An early RLAST and a missing RLAST on the final beat are both length errors.
    assign len_bad      = RLAST_S ? (beat_q != req_q.len) : (beat_q == req_q.len);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARVALID_S  = 1'b0;
        RVALID_M0  = 1'b0;
        RVALID_M1  = 1'b0;
        RREADY_S   = 1'b0;
        case (state_q)
            IDLE: begin
                ARREADY_M0 = gnt[0];
                ARREADY_M1 = gnt[1];
                if (|gnt) state_d = ADDR;
            end
            ADDR: begin
                ARVALID_S = 1'b1;
                if (ARREADY_S) state_d = DATA;
            end
            DATA: begin
                RVALID_M0 = RVALID_S && (owner_q == M0);
                RVALID_M1 = RVALID_S && (owner_q == M1);
                RREADY_S  = owner_rready;
                if (r_hs && RLAST_S) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            rr_prio_q  <= M0;
            owner_q    <= M0;
            beat_q     <= '0;
            req_q      <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (|gnt)) begin
                owner_q <= gnt[1];
                req_q   <= win_req;
                beat_q  <= '0;
            end
            if (r_hs) begin
                beat_q <= beat_q + 1'b1;
                if (RLAST_S)            rr_prio_q  <= ~owner_q;
                if (rid_bad || len_bad) prot_err_q <= 1'b1;
            end
        end
    end

    assign ARID_S    = {{(IDSW-IDW-1){1'b0}}, owner_q, req_q.id};
    assign ARADDR_S  = req_q.addr;
    assign ARLEN_S   = req_q.len;
    assign ARSIZE_S  = req_q.size;
    assign ARBURST_S = req_q.burst;

    // R payload fans out to both masters; only the owner's RVALID qualifies it.
    assign RID_M0   = RID_S[IDW-1:0];
    assign RDATA_M0 = RDATA_S;
    assign RRESP_M0 = RRESP_S;
    assign RLAST_M0 = RLAST_S;
    assign RID_M1   = RID_S[IDW-1:0];
    assign RDATA_M1 = RDATA_S;
    assign RRESP_M1 = RRESP_S;
    assign RLAST_M1 = RLAST_S;

    assign PROT_ERR      = prot_err_q;
    assign unused_rid_hi = ^RID_S[IDSW-1:IDW+1];

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Directed bench for dram_rd_arbiter: a per-cycle vector table plus hand-written
// sequences for back-pressure, length violation, mid-burst reset and RID mismatch.
module tb_dram_rd_arbiter;
    import arb_pkg::*;

    logic        ACLK, ARESET;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S, RID_S;
    logic [31:0] ARADDR_S, RDATA_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S, RRESP_S;
    logic        ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S, PROT_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    dram_rd_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0),
        .ARREADY_M0(ARREADY_M0), .RID_M0(RID_M0), .RDATA_M0(RDATA_M0),
        .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M1(ARREADY_M1), .RID_M1(RID_M1), .RDATA_M1(RDATA_M1),
        .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .PROT_ERR(PROT_ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       arv0, arv1, arrs, rvs, rlast, rr0, rr1;
        logic [7:0] rid_s;
        logic       e_arr0, e_arr1, e_arvs, e_rv0, e_rv1, e_rrs;
        logic [7:0] e_arid;
        logic       e_prio, e_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven 1 time unit after it.
    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        RID_S = 8'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESET = 1'b1;
        next_cycle();
        ARESET = 1'b0;
    endtask

    // Grant master m from IDLE and pass the ADDR cycle with ARREADY_S high.
    task automatic accept_and_addr(input logic m);
        if (m == M1) ARVALID_M1 = 1'b1; else ARVALID_M0 = 1'b1;
        ARREADY_S = 1'b1;
        settle();
        check("acc_arready", 32'(m == M1 ? ARREADY_M1 : ARREADY_M0), 32'd1);
        next_cycle();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0;
        settle();
        check("acc_arvalid_s", 32'(ARVALID_S), 32'd1);
        next_cycle();
        ARREADY_S = 1'b0;
    endtask

    task automatic beat(input logic m, input logic last, input logic [7:0] rid);
        RVALID_S = 1'b1; RLAST_S = last; RID_S = rid;
        if (m == M1) RREADY_M1 = 1'b1; else RREADY_M0 = 1'b1;
        settle();
        check("beat_rvalid", 32'(m == M1 ? RVALID_M1 : RVALID_M0), 32'd1);
        next_cycle();
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    endtask

    initial begin
        logic rr_pat [6];
        int   beat_pat [6];

        ARID_M0 = 4'd5; ARADDR_M0 = 32'h0000_2000; ARLEN_M0 = 4'd0;
        ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
        ARID_M1 = 4'd3; ARADDR_M1 = 32'h0000_1000; ARLEN_M1 = 4'd0;
        ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'd1;
        RDATA_S = 32'hDEAD_BEEF; RRESP_S = 2'd0;
        clear_inputs();
        ARESET = 1'b1;
        next_cycle();
        do_reset();

        settle();
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_prio", 32'(dut.rr_prio_q), 32'(M0));
        check("rst_arvalid_s", 32'(ARVALID_S), 32'd0);
        check("rst_rready_s", 32'(RREADY_S), 32'd0);
        check("rst_arid_s", 32'(ARID_S), 32'd0);
        check("rst_prot_err", 32'(PROT_ERR), 32'd0);

        //           arv0 arv1 arrs rvs rlast rr0 rr1 rid_s  arr0 arr1 arvs rv0 rv1 rrs arid   prio err
        vecs[0] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h13,1'b0,1'b0};
        vecs[2] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'h13, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h13,1'b0,1'b0};
        vecs[3] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h13,1'b0,1'b0};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h05,1'b0,1'b0};
        vecs[5] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h05, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,8'h05,1'b0,1'b0};
        vecs[6] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h05,1'b1,1'b0};
        vecs[7] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h13,1'b1,1'b0};
        vecs[8] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,8'h13, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h13,1'b1,1'b0};
        vecs[9] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h13,1'b0,1'b0};

        for (int i = 0; i < 10; i++) begin
            ARVALID_M0 = vecs[i].arv0; ARVALID_M1 = vecs[i].arv1; ARREADY_S = vecs[i].arrs;
            RVALID_S = vecs[i].rvs; RLAST_S = vecs[i].rlast;
            RREADY_M0 = vecs[i].rr0; RREADY_M1 = vecs[i].rr1; RID_S = vecs[i].rid_s;
            settle();
            check($sformatf("v%0d_arready_m0", i), 32'(ARREADY_M0), 32'(vecs[i].e_arr0));
            check($sformatf("v%0d_arready_m1", i), 32'(ARREADY_M1), 32'(vecs[i].e_arr1));
            check($sformatf("v%0d_arvalid_s", i), 32'(ARVALID_S), 32'(vecs[i].e_arvs));
            check($sformatf("v%0d_rvalid_m0", i), 32'(RVALID_M0), 32'(vecs[i].e_rv0));
            check($sformatf("v%0d_rvalid_m1", i), 32'(RVALID_M1), 32'(vecs[i].e_rv1));
            check($sformatf("v%0d_rready_s", i), 32'(RREADY_S), 32'(vecs[i].e_rrs));
            check($sformatf("v%0d_arid_s", i), 32'(ARID_S), 32'(vecs[i].e_arid));
            check($sformatf("v%0d_prio", i), 32'(dut.rr_prio_q), 32'(vecs[i].e_prio));
            check($sformatf("v%0d_prot_err", i), 32'(PROT_ERR), 32'(vecs[i].e_err));
            if (vecs[i].e_arvs)
                check($sformatf("v%0d_araddr_s", i), ARADDR_S,
                      vecs[i].e_arid[4] ? 32'h0000_1000 : 32'h0000_2000);
            if (vecs[i].e_rv1) begin
                check($sformatf("v%0d_rdata_m1", i), RDATA_M1, 32'hDEAD_BEEF);
                check($sformatf("v%0d_rid_m1", i), 32'(RID_M1), 32'd3);
            end
            if (vecs[i].e_rv0) begin
                check($sformatf("v%0d_rdata_m0", i), RDATA_M0, 32'hDEAD_BEEF);
                check($sformatf("v%0d_rid_m0", i), 32'(RID_M0), 32'd5);
            end
            next_cycle();
        end
        clear_inputs();

        // Back-pressure: ARREADY_S low 5 cycles, then a 4-beat burst with RREADY_M0 stalls.
        ARADDR_M0 = 32'h0000_4000; ARLEN_M0 = 4'd3;
        ARVALID_M0 = 1'b1;
        settle();
        check("bp_arready_m0", 32'(ARREADY_M0), 32'd1);
        next_cycle();
        ARVALID_M0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("bp_hold%0d_arvalid_s", k), 32'(ARVALID_S), 32'd1);
            check($sformatf("bp_hold%0d_araddr_s", k), ARADDR_S, 32'h0000_4000);
            check($sformatf("bp_hold%0d_arlen_s", k), 32'(ARLEN_S), 32'd3);
            next_cycle();
        end
        ARREADY_S = 1'b1;
        settle();
        check("bp_arvalid_s_go", 32'(ARVALID_S), 32'd1);
        next_cycle();
        ARREADY_S = 1'b0;
        rr_pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        beat_pat = '{0, 1, 1, 2, 3, 3};
        RID_S = 8'h05; RVALID_S = 1'b1;
        for (int k = 0; k < 6; k++) begin
            RREADY_M0 = rr_pat[k];
            RLAST_S   = (k == 5);
            settle();
            check($sformatf("bp_b%0d_rready_s", k), 32'(RREADY_S), 32'(rr_pat[k]));
            check($sformatf("bp_b%0d_beat", k), 32'(dut.beat_q), 32'(beat_pat[k]));
            next_cycle();
        end
        clear_inputs();
        settle();
        check("bp_end_state", 32'(dut.state_q), 32'(IDLE));
        check("bp_end_prot_err", 32'(PROT_ERR), 32'd0);
        check("bp_end_prio", 32'(dut.rr_prio_q), 32'(M1));

        // Length violation: LEN=3 with RLAST on the second beat.
        ARLEN_M1 = 4'd3;
        accept_and_addr(M1);
        beat(M1, 1'b0, 8'h13);
        settle();
        check("lv_err_before", 32'(PROT_ERR), 32'd0);
        beat(M1, 1'b1, 8'h13);
        settle();
        check("lv_err_set", 32'(PROT_ERR), 32'd1);
        check("lv_state", 32'(dut.state_q), 32'(IDLE));
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            check($sformatf("lv_sticky%0d", k), 32'(PROT_ERR), 32'd1);
        end
        do_reset();
        settle();
        check("lv_err_cleared", 32'(PROT_ERR), 32'd0);

        // Reset mid-DATA after beat 1 of a 4-beat M1 burst, with prio moved to M1 first.
        ARLEN_M0 = 4'd0;
        accept_and_addr(M0);
        beat(M0, 1'b1, 8'h05);
        settle();
        check("rst_mid_prio_pre", 32'(dut.rr_prio_q), 32'(M1));
        accept_and_addr(M1);
        beat(M1, 1'b0, 8'h13);
        beat(M1, 1'b0, 8'h13);
        ARESET = 1'b1;
        next_cycle();
        ARESET = 1'b0;
        RVALID_S = 1'b1; RREADY_M1 = 1'b1; RID_S = 8'h13;
        settle();
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_mid_prio", 32'(dut.rr_prio_q), 32'(M0));
        check("rst_mid_valids", 32'({ARREADY_M0, ARREADY_M1, RVALID_M0, RVALID_M1,
                                     ARVALID_S, RREADY_S}), 32'd0);
        next_cycle();
        clear_inputs();

        // RID owner mismatch: owner M0 but RID_S carries owner bit 1.
        accept_and_addr(M0);
        RVALID_S = 1'b1; RLAST_S = 1'b1; RID_S = 8'h15; RDATA_S = 32'hCAFE_F00D; RREADY_M0 = 1'b1;
        settle();
        check("rid_rvalid_m0", 32'(RVALID_M0), 32'd1);
        check("rid_rvalid_m1", 32'(RVALID_M1), 32'd0);
        check("rid_rdata_m0", RDATA_M0, 32'hCAFE_F00D);
        check("rid_rid_m0", 32'(RID_M0), 32'd5);
        check("rid_err_before", 32'(PROT_ERR), 32'd0);
        next_cycle();
        clear_inputs();
        settle();
        check("rid_err_set", 32'(PROT_ERR), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
